// File: rtl/lock_event_monitor.sv
// Lock-loss monitor: synchronizes and debounces an async PLL/MMCM locked flag, counts confirmed
// losses and measures unlock durations in clk_ref cycles. Optional timestamps: LOCK_MON_TIMESTAMP_EN.
module lock_event_monitor #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 32,
  parameter int DUR_WIDTH       = 24,
  parameter int TS_WIDTH        = 48
) (
  input  logic                 clk_ref,
  input  logic                 reset_in,
  input  logic                 locked,
  input  logic                 clear,
  output logic                 locked_stable,
  output logic                 unlock_pulse,
  output logic                 relock_pulse,
  output logic [CNT_WIDTH-1:0] unlocks,
  output logic [DUR_WIDTH-1:0] last_unlock_len,
  output logic [DUR_WIDTH-1:0] max_unlock_len
`ifdef LOCK_MON_TIMESTAMP_EN
  ,
  output logic [TS_WIDTH-1:0]  timestamp,
  output logic [TS_WIDTH-1:0]  loss_timestamp
`endif
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {UNLOCKED, GAIN_DB, LOCKED, LOSS_DB} state_e;

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || TS_WIDTH < 1) begin : g_param_check
    $error("lock_event_monitor: invalid parameter values");
  end

  function automatic logic [CNT_WIDTH-1:0] sat_inc_cnt(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  function automatic logic [DUR_WIDTH-1:0] sat_inc_dur(input logic [DUR_WIDTH-1:0] v);
    return (&v) ? v : v + DUR_WIDTH'(1);
  endfunction

  function automatic logic [DUR_WIDTH-1:0] dur_max(input logic [DUR_WIDTH-1:0] a,
                                                   input logic [DUR_WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  state_e                 state_q, state_d;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic [DUR_WIDTH-1:0]   dur_q, dur_d, dur_run;
  logic [CNT_WIDTH-1:0]   unlocks_q, unlocks_d;
  logic [DUR_WIDTH-1:0]   last_q, last_d, max_q, max_d;
  logic                   had_loss_q, had_loss_d;
  logic                   unlock_pulse_q, relock_pulse_q;
  logic                   loss_evt, gain_evt, s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    loss_evt = 1'b0;
    gain_evt = 1'b0;
    unique case (state_q)
      UNLOCKED: if (s) begin
        state_d  = GAIN_DB;
        db_cnt_d = DB_W'(1);
      end
      GAIN_DB: if (!s) begin
        state_d = UNLOCKED;
      end else if (db_cnt_q == DB_LAST) begin
        state_d  = LOCKED;
        gain_evt = 1'b1;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
      LOCKED: if (!s) begin
        state_d  = LOSS_DB;
        db_cnt_d = DB_W'(1);
      end
      LOSS_DB: if (s) begin
        state_d = LOCKED;
      end else if (db_cnt_q == DB_LAST) begin
        state_d  = UNLOCKED;
        loss_evt = 1'b1;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
      default: state_d = UNLOCKED;
    endcase
  end

  // Duration counts every cycle spent unlocked, including the relock cycle itself.
  always_comb begin
    dur_run    = (state_q == UNLOCKED || state_q == GAIN_DB) ? sat_inc_dur(dur_q) : dur_q;
    dur_d      = loss_evt ? '0 : dur_run;
    had_loss_d = had_loss_q | loss_evt;
    unlocks_d  = clear ? '0 : unlocks_q;
    last_d     = clear ? '0 : last_q;
    max_d      = clear ? '0 : max_q;
    if (loss_evt) unlocks_d = sat_inc_cnt(unlocks_d);
    if (gain_evt && had_loss_q) begin
      last_d = dur_run;
      max_d  = dur_max(max_d, dur_run);
    end
  end

  always_ff @(posedge clk_ref or posedge reset_in) begin
    if (reset_in) begin
      sync_q         <= '0;
      state_q        <= UNLOCKED;
      db_cnt_q       <= '0;
      dur_q          <= '0;
      unlocks_q      <= '0;
      last_q         <= '0;
      max_q          <= '0;
      had_loss_q     <= 1'b0;
      unlock_pulse_q <= 1'b0;
      relock_pulse_q <= 1'b0;
    end else begin
      sync_q         <= {sync_q[SYNC_STAGES-2:0], locked};
      state_q        <= state_d;
      db_cnt_q       <= db_cnt_d;
      dur_q          <= dur_d;
      unlocks_q      <= unlocks_d;
      last_q         <= last_d;
      max_q          <= max_d;
      had_loss_q     <= had_loss_d;
      unlock_pulse_q <= loss_evt;
      relock_pulse_q <= gain_evt;
    end
  end

  assign locked_stable   = (state_q == LOCKED) || (state_q == LOSS_DB);
  assign unlock_pulse    = unlock_pulse_q;
  assign relock_pulse    = relock_pulse_q;
  assign unlocks         = unlocks_q;
  assign last_unlock_len = last_q;
  assign max_unlock_len  = max_q;

`ifdef LOCK_MON_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q, ts_d, loss_ts_q, loss_ts_d;

  // Capture the value the timestamp shows while unlock_pulse is high.
  always_comb begin
    ts_d      = ts_q + TS_WIDTH'(1);
    loss_ts_d = loss_evt ? ts_d : (clear ? '0 : loss_ts_q);
  end

  always_ff @(posedge clk_ref or posedge reset_in) begin
    if (reset_in) begin
      ts_q      <= '0;
      loss_ts_q <= '0;
    end else begin
      ts_q      <= ts_d;
      loss_ts_q <= loss_ts_d;
    end
  end

  assign timestamp      = ts_q;
  assign loss_timestamp = loss_ts_q;
`endif

endmodule

// File: tb/tb_lock_event_monitor.sv
// Randomized scoreboard bench for lock_event_monitor against a sample-window reference model.
module tb_lock_event_monitor;
  localparam int SYNC  = 2;
  localparam int DB    = 4;
  localparam int CNT_W = 4;
  localparam int DUR_W = 6;
  localparam int W     = SYNC + DB + 1;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int DMAX  = (1 << DUR_W) - 1;

  logic             clk = 1'b0;
  logic             reset_in, locked, clear;
  logic             locked_stable, unlock_pulse, relock_pulse;
  logic [CNT_W-1:0] unlocks;
  logic [DUR_W-1:0] last_unlock_len, max_unlock_len;
`ifdef LOCK_MON_TIMESTAMP_EN
  logic [47:0]      ts, loss_ts;
`endif

  lock_event_monitor #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .CNT_WIDTH(CNT_W), .DUR_WIDTH(DUR_W), .TS_WIDTH(48)
  ) dut (
    .clk_ref(clk), .reset_in(reset_in), .locked(locked), .clear(clear),
    .locked_stable(locked_stable), .unlock_pulse(unlock_pulse), .relock_pulse(relock_pulse),
    .unlocks(unlocks), .last_unlock_len(last_unlock_len), .max_unlock_len(max_unlock_len)
`ifdef LOCK_MON_TIMESTAMP_EN
    , .timestamp(ts), .loss_timestamp(loss_ts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit stable; bit up; bit rp; int unl; int last; int mx;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   n_cmp = 0, n_fail = 0;
  int   cyc = 0, relock_cyc = -1;

  // Reference model state: raw locked samples per edge, newest at the back.
  bit   lq[$];
  bit   m_stable, m_had;
  int   m_unl, m_last, m_max, m_n = 0, m_loss_n = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    lq.delete();
    for (int i = 0; i < W; i++) lq.push_back(1'b0);
    m_stable = 0; m_had = 0; m_unl = 0; m_last = 0; m_max = 0;
  endtask

  // Called at a negedge: drives one cycle of inputs, predicts the following edge, waits a cycle.
  task automatic step(input bit l, input bit c, input bit clr_on_evt);
    bit all1, all0, ev_up, ev_rp, cl;
    int d;
    exp_t e;
    locked = l;
    lq.push_back(l);
    void'(lq.pop_front());
    all1 = 1; all0 = 1;
    for (int i = 0; i <= DB; i++) begin
      if (lq[i]) all0 = 0; else all1 = 0;
    end
    ev_rp = !m_stable && all1;
    ev_up = m_stable && all0;
    cl = c | (clr_on_evt & (ev_up | ev_rp));
    clear = cl;
    m_n++;
    if (cl) begin m_unl = 0; m_last = 0; m_max = 0; end
    if (ev_up) begin
      m_stable = 0;
      m_unl = (m_unl < CMAX) ? m_unl + 1 : CMAX;
      m_loss_n = m_n;
      m_had = 1;
    end
    if (ev_rp) begin
      m_stable = 1;
      if (m_had) begin
        d = m_n - m_loss_n;
        if (d > DMAX) d = DMAX;
        m_last = d;
        if (d > m_max) m_max = d;
      end
    end
    e.stable = m_stable; e.up = ev_up; e.rp = ev_rp;
    e.unl = m_unl; e.last = m_last; e.mx = m_max;
    expq.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset(input int ncyc);
    exp_t e;
    reset_in = 1'b1;
    clear = 1'b0;
    #1;
    check("rst_locked_stable", locked_stable, 0);
    check("rst_unlock_pulse", unlock_pulse, 0);
    check("rst_relock_pulse", relock_pulse, 0);
    check("rst_unlocks", unlocks, 0);
    check("rst_last", last_unlock_len, 0);
    check("rst_max", max_unlock_len, 0);
    model_reset();
    e.stable = 0; e.up = 0; e.rp = 0; e.unl = 0; e.last = 0; e.mx = 0;
    for (int i = 0; i < ncyc; i++) begin
      expq.push_back(e);
      @(negedge clk);
    end
    reset_in = 1'b0;
  endtask

  // Monitor: one expected snapshot per clock edge, compared just after the edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (relock_pulse) relock_cyc = cyc;
    if (expq.size() > 0) begin
      mon_e = expq.pop_front();
      check("locked_stable", locked_stable, mon_e.stable);
      check("unlock_pulse", unlock_pulse, mon_e.up);
      check("relock_pulse", relock_pulse, mon_e.rp);
      check("unlocks", unlocks, mon_e.unl);
      check("last_unlock_len", last_unlock_len, mon_e.last);
      check("max_unlock_len", max_unlock_len, mon_e.mx);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rise_cyc, len;
    bit lvl;
    reset_in = 1'b1; locked = 1'b0; clear = 1'b0;
    @(negedge clk);
    do_reset(3);

    // First lock after reset
    repeat (100) step(0, 0, 0);
    rise_cyc = cyc + 1;
    repeat (20) step(1, 0, 0);
    check("first_lock_latency", relock_cyc - rise_cyc, 6);
    check("first_lock_unlocks", unlocks, 0);
    check("first_lock_last", last_unlock_len, 0);

    // Short glitch
    repeat (3) step(0, 0, 0);
    repeat (20) step(1, 0, 0);
    check("glitch_stable", locked_stable, 1);
    check("glitch_unlocks", unlocks, 0);

    // Outages of 50 and 20 cycles, then clear
    repeat (50) step(0, 0, 0);
    repeat (20) step(1, 0, 0);
    check("out50_unlocks", unlocks, 1);
    check("out50_last", last_unlock_len, 50);
    check("out50_max", max_unlock_len, 50);
    repeat (20) step(0, 0, 0);
    repeat (20) step(1, 0, 0);
    check("out20_unlocks", unlocks, 2);
    check("out20_last", last_unlock_len, 20);
    check("out20_max", max_unlock_len, 50);
    step(1, 1, 0);
    check("clear_unlocks", unlocks, 0);
    check("clear_last", last_unlock_len, 0);
    check("clear_max", max_unlock_len, 0);
    check("clear_stable", locked_stable, 1);

    // Saturation of count and duration
    repeat (17) begin
      repeat (20) step(0, 0, 0);
      repeat (20) step(1, 0, 0);
    end
    check("sat_unlocks", unlocks, CMAX);
    repeat (80) step(0, 0, 0);
    repeat (20) step(1, 0, 0);
    check("sat_last", last_unlock_len, DMAX);

    // Reset in the middle of an outage discards the duration
    repeat (30) step(0, 0, 0);
    do_reset(2);
    repeat (20) step(1, 0, 0);
    check("post_rst_stable", locked_stable, 1);
    check("post_rst_last", last_unlock_len, 0);
    check("post_rst_unlocks", unlocks, 0);

    // Randomized level runs, clears and resets
    lvl = 1'b1;
    for (int seg = 0; seg < 400; seg++) begin
      lvl = !lvl;
      len = ($urandom_range(0, 9) < 5) ? $urandom_range(1, 6) : $urandom_range(5, 90);
      for (int k = 0; k < len; k++)
        step(lvl, $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 49) == 0) do_reset($urandom_range(1, 4));
    end

    @(negedge clk);
    check("queue_drain", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
